// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - multi-channel tick-driven timeout scheduler with round-robin event drain
// Optional sticky per-channel overrun flags: define TIMER_SCHED_OVERRUN_EN.
module timer_sched #(
  parameter int NUM_CHAN     = 4,
  parameter int CHAN_WIDTH   = 2,
  parameter int RELOAD_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    tick_in,
  input  logic                    cfg_valid_in,
  input  logic [CHAN_WIDTH-1:0]   cfg_chan_in,
  input  logic [RELOAD_WIDTH-1:0] cfg_reload_in,
  input  logic                    cfg_enable_in,
  input  logic                    cfg_periodic_in,
  output logic [NUM_CHAN-1:0]     armed_out,
  output logic                    evt_valid_out,
  output logic [CHAN_WIDTH-1:0]   evt_chan_out,
  input  logic                    evt_ready_in,
  output logic [NUM_CHAN-1:0]     ovr_out
);

  logic [RELOAD_WIDTH-1:0] count_q  [NUM_CHAN];
  logic [RELOAD_WIDTH-1:0] count_d  [NUM_CHAN];
  logic [RELOAD_WIDTH-1:0] reload_q [NUM_CHAN];
  logic [RELOAD_WIDTH-1:0] reload_d [NUM_CHAN];
  logic [NUM_CHAN-1:0]     armed_q, armed_d;
  logic [NUM_CHAN-1:0]     periodic_q, periodic_d;
  logic [NUM_CHAN-1:0]     pending_q, pending_d;
  logic [CHAN_WIDTH-1:0]   rr_q, rr_d;
  logic                    evt_valid_q, evt_valid_d;
  logic [CHAN_WIDTH-1:0]   evt_chan_q, evt_chan_d;

  logic [NUM_CHAN-1:0]     cfg_hit;
  logic [NUM_CHAN-1:0]     cand;
  logic                    hi_found, lo_found;
  logic [CHAN_WIDTH-1:0]   hi_idx, lo_idx, sel;
  logic                    load;
  logic                    load_clr;

`ifdef TIMER_SCHED_OVERRUN_EN
  logic [NUM_CHAN-1:0]     ovr_q, ovr_d;
  assign ovr_out = ovr_q;
`else
  assign ovr_out = '0;
`endif

  assign armed_out     = armed_q;
  assign evt_valid_out = evt_valid_q;
  assign evt_chan_out  = evt_chan_q;

  // A channel being reconfigured this cycle is not eligible for selection.
  always_comb begin
    cfg_hit = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      cfg_hit[c] = cfg_valid_in && (cfg_chan_in == CHAN_WIDTH'(c));
    end
    cand     = pending_q & ~cfg_hit;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (!hi_found && cand[c] && (CHAN_WIDTH'(c) >= rr_q)) begin
        hi_found = 1'b1;
        hi_idx   = CHAN_WIDTH'(c);
      end
      if (!lo_found && cand[c]) begin
        lo_found = 1'b1;
        lo_idx   = CHAN_WIDTH'(c);
      end
    end
    sel  = hi_found ? hi_idx : lo_idx;
    load = !evt_valid_q || evt_ready_in;
  end

  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    armed_d     = armed_q;
    periodic_d  = periodic_q;
    pending_d   = pending_q;
    rr_d        = rr_q;
    evt_valid_d = evt_valid_q;
    evt_chan_d  = evt_chan_q;
    load_clr    = 1'b0;
`ifdef TIMER_SCHED_OVERRUN_EN
    ovr_d       = ovr_q;
`endif
    if (load) begin
      evt_valid_d = lo_found;
      if (lo_found) begin
        evt_chan_d = sel;
        rr_d       = (sel == CHAN_WIDTH'(NUM_CHAN - 1)) ? '0 : sel + CHAN_WIDTH'(1);
      end
    end
    for (int c = 0; c < NUM_CHAN; c++) begin
      load_clr = load && lo_found && (sel == CHAN_WIDTH'(c));
      if (load_clr) pending_d[c] = 1'b0;
      if (cfg_hit[c]) begin
        reload_d[c]   = cfg_reload_in;
        count_d[c]    = cfg_reload_in;
        armed_d[c]    = cfg_enable_in;
        periodic_d[c] = cfg_periodic_in;
        pending_d[c]  = 1'b0;
`ifdef TIMER_SCHED_OVERRUN_EN
        ovr_d[c]      = 1'b0;
`endif
      end else if (tick_in && armed_q[c]) begin
        if (count_q[c] != '0) begin
          count_d[c] = count_q[c] - RELOAD_WIDTH'(1);
        end else begin
          // Set after the load clear so an expiry racing its own drain is kept.
          pending_d[c] = 1'b1;
`ifdef TIMER_SCHED_OVERRUN_EN
          if (pending_q[c] && !load_clr) ovr_d[c] = 1'b1;
`endif
          if (periodic_q[c]) count_d[c] = reload_q[c];
          else               armed_d[c] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      count_q     <= '{default: '0};
      reload_q    <= '{default: '0};
      armed_q     <= '0;
      periodic_q  <= '0;
      pending_q   <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
`ifdef TIMER_SCHED_OVERRUN_EN
      ovr_q       <= '0;
`endif
    end else begin
      count_q     <= count_d;
      reload_q    <= reload_d;
      armed_q     <= armed_d;
      periodic_q  <= periodic_d;
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_chan_q  <= evt_chan_d;
`ifdef TIMER_SCHED_OVERRUN_EN
      ovr_q       <= ovr_d;
`endif
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - scoreboard bench for timer_sched
module tb_timer_sched;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick;
  logic          cfg_valid;
  logic [CW-1:0] cfg_chan;
  logic [RW-1:0] cfg_reload;
  logic          cfg_enable;
  logic          cfg_periodic;
  logic [N-1:0]  armed;
  logic          evt_valid;
  logic [CW-1:0] evt_chan;
  logic          evt_ready;
  logic [N-1:0]  ovr;

  typedef struct {
    int chan;
    int when;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_sched #(.NUM_CHAN(N), .CHAN_WIDTH(CW), .RELOAD_WIDTH(RW)) dut (
    .clk_in          (clk),
    .reset_n_in      (reset_n),
    .tick_in         (tick),
    .cfg_valid_in    (cfg_valid),
    .cfg_chan_in     (cfg_chan),
    .cfg_reload_in   (cfg_reload),
    .cfg_enable_in   (cfg_enable),
    .cfg_periodic_in (cfg_periodic),
    .armed_out       (armed),
    .evt_valid_out   (evt_valid),
    .evt_chan_out    (evt_chan),
    .evt_ready_in    (evt_ready),
    .ovr_out         (ovr)
  );

  // Monitor: every accepted event is matched against the scoreboard (channel and cycle).
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_evt: got chan=%0d at cyc=%0d, required no event", evt_chan, cyc);
      end else begin
        mon_e = q.pop_front();
        if (int'(evt_chan) != mon_e.chan || cyc != mon_e.when) begin
          bad++;
          $display("FAIL evt: got chan=%0d at cyc=%0d, required chan=%0d at cyc=%0d",
                   evt_chan, cyc, mon_e.chan, mon_e.when);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic expect_evt(input int chan, input int when);
    exp_t e;
    e.chan = chan;
    e.when = when;
    q.push_back(e);
  endtask

  task automatic cfg(input int c, input int r, input int en, input int per);
    cfg_valid    = 1'b1;
    cfg_chan     = CW'(c);
    cfg_reload   = RW'(r);
    cfg_enable   = en[0];
    cfg_periodic = per[0];
    step(1);
    cfg_valid    = 1'b0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    tick      = 1'b0;
    cfg_valid = 1'b0;
    evt_ready = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    reset_n      = 1'b0;
    tick         = 1'b0;
    cfg_valid    = 1'b0;
    cfg_chan     = '0;
    cfg_reload   = '0;
    cfg_enable   = 1'b0;
    cfg_periodic = 1'b0;
    evt_ready    = 1'b0;
    step(2);
    check("rst_armed", int'(armed), 0);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_chan", int'(evt_chan), 0);
    check("rst_ovr", int'(ovr), 0);
    reset_n = 1'b1;
    step(1);

    // T1: asynchronous reset with an event held in the output register
    do_reset();
    cfg(0, 0, 1, 1);
    tick = 1'b1;
    step(3);
    tick = 1'b0;
    check("t1_armed_pre", int'(armed), 1);
    check("t1_valid_pre", int'(evt_valid), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("t1_async_armed", int'(armed), 0);
    check("t1_async_valid", int'(evt_valid), 0);
    check("t1_async_ovr", int'(ovr), 0);
    @(posedge clk);
    #1;
    step(1);
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    tick      = 1'b1;
    step(5);
    tick = 1'b0;
    step(2);
    check("t1_armed_post", int'(armed), 0);

    // T2: ch1 R=3 periodic, event every 4 ticks, 2-cycle latency
    do_reset();
    evt_ready = 1'b1;
    cfg(1, 3, 1, 1);
    b = cyc;
    expect_evt(1, b + 5);
    expect_evt(1, b + 9);
    expect_evt(1, b + 13);
    tick = 1'b1;
    step(12);
    tick = 1'b0;
    step(3);
    check("t2_drained", q.size(), 0);

    // T3: ch0 R=2 one-shot
    do_reset();
    evt_ready = 1'b1;
    cfg(0, 2, 1, 0);
    b = cyc;
    expect_evt(0, b + 4);
    tick = 1'b1;
    step(6);
    tick = 1'b0;
    step(2);
    check("t3_armed", int'(armed), 0);
    check("t3_drained", q.size(), 0);

    // T4: round-robin drain after back-pressure
    do_reset();
    for (int c = 0; c < N; c++) cfg(c, 0, 1, 1);
    check("t4_armed", int'(armed), 15);
    tick = 1'b1;
    step(10);
    check("t4_hold_valid", int'(evt_valid), 1);
    check("t4_hold_chan", int'(evt_chan), 0);
    tick      = 1'b0;
    evt_ready = 1'b1;
    b = cyc;
    expect_evt(0, b);
    expect_evt(1, b + 1);
    expect_evt(2, b + 2);
    expect_evt(3, b + 3);
    expect_evt(0, b + 4);
    step(6);
    check("t4_drained", q.size(), 0);
    check("t4_idle", int'(evt_valid), 0);

    // T5: config/tick collision, then expiry during own drain
    do_reset();
    evt_ready = 1'b1;
    cfg(2, 0, 1, 1);
    b = cyc;
    expect_evt(2, b + 3);
    expect_evt(2, b + 4);
    tick = 1'b1;
    cfg(2, 0, 1, 1);
    step(2);
    tick = 1'b0;
    step(3);
    check("t5_drained", q.size(), 0);

    // T6: repeated expiry while pending
    do_reset();
    cfg(3, 0, 1, 1);
    tick = 1'b1;
    step(3);
    tick = 1'b0;
`ifdef TIMER_SCHED_OVERRUN_EN
    check("t6_ovr_set", int'(ovr), 8);
    cfg(3, 0, 0, 1);
    check("t6_ovr_clr", int'(ovr), 0);
`else
    check("t6_ovr_off", int'(ovr), 0);
`endif
    do_reset();
    check("end_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
